// File: rtl/req_initiator_pkg.sv
// Shared types and constants for the req/gnt requester.
package req_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    RELEASE
  } state_t;

  localparam int GRANT_CNT_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [GRANT_CNT_W-1:0] satInc(input logic [GRANT_CNT_W-1:0] value);
    return (value == '1) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/req_initiator_if.sv
// Single-bit request/grant handshake between a requester and an arbiter.
interface req_initiator_if;

  logic req;
  logic gnt;

  modport master (output req, input gnt);
  modport slave  (input req, output gnt);

endinterface

// File: rtl/req_initiator.sv
// Requester side of the req/gnt handshake: raises req on start, holds it for a
// programmed number of cycles after grant, then waits for the grant to drop.
// Reports grant latency, timeouts, lost grants and a count of completions.
module req_initiator
  import req_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [CNT_W-1:0]       hold_cycles,
  req_initiator_if.master        bus,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic                   gnt_lost,
  output logic [CNT_W-1:0]       lat,
  output logic [GRANT_CNT_W-1:0] grant_cnt
);

  // Last value of the shared wait counter before a wait is abandoned.
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  state_t                 r_state;
  logic                   r_req;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_timeout;
  logic                   r_gntLost;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_hold;
  logic [CNT_W-1:0]       r_lat;
  logic [GRANT_CNT_W-1:0] r_grantCnt;

  // Whole handshake sequencer: state, counters and every registered output.
  // r_cnt serves both the grant wait in REQ and the release wait in RELEASE;
  // r_hold captures hold_cycles at start and is counted down in HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
      r_gntLost  <= 1'b0;
      r_cnt      <= '0;
      r_hold     <= '0;
      r_lat      <= '0;
      r_grantCnt <= '0;
    end else begin
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_gntLost <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= REQ;
            r_req   <= 1'b1;
            r_busy  <= 1'b1;
            r_hold  <= hold_cycles;
            r_cnt   <= '0;
          end
        end
        REQ: begin
          if (bus.gnt) begin
            r_lat   <= r_cnt;
            r_state <= HOLD;
          end else if (r_cnt == LIMIT) begin
            r_req     <= 1'b0;
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (!bus.gnt) begin
            r_gntLost <= 1'b1;
            r_req     <= 1'b0;
            r_cnt     <= '0;
            r_state   <= RELEASE;
          end else if (r_hold == '0) begin
            r_req   <= 1'b0;
            r_cnt   <= '0;
            r_state <= RELEASE;
          end else begin
            r_hold <= r_hold - 1'b1;
          end
        end
        RELEASE: begin
          if (!bus.gnt) begin
            r_done     <= 1'b1;
            r_grantCnt <= satInc(r_grantCnt);
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end else if (r_cnt == LIMIT) begin
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req   = r_req;
  assign busy      = r_busy;
  assign done      = r_done;
  assign timeout   = r_timeout;
  assign gnt_lost  = r_gntLost;
  assign lat       = r_lat;
  assign grant_cnt = r_grantCnt;

endmodule

// File: tb/tb_req_initiator.sv
// Randomized bench for req_initiator: a reactive arbiter drives gnt, and a
// transaction-level model predicts, from the arbiter's chosen grant delay,
// drop point and hold length, on which edge each output event must occur.
module tb_req_initiator;
  import req_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 8;

  localparam int NORMAL = 0;
  localparam int NEVER  = 1;
  localparam int DROP   = 2;
  localparam int STUCK  = 3;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   start;
  logic [CNT_W-1:0]       holdCycles;
  logic                   busy;
  logic                   done;
  logic                   timeout;
  logic                   gntLost;
  logic [CNT_W-1:0]       lat;
  logic [GRANT_CNT_W-1:0] grantCnt;

  req_initiator_if bus();

  req_initiator #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .hold_cycles(holdCycles),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .gnt_lost   (gntLost),
    .lat        (lat),
    .grant_cnt  (grantCnt)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  int checkCount   = 0;
  int errorCount   = 0;
  int expLat       = 0;
  int expGrantCnt  = 0;

  int arbMode      = NORMAL;
  int arbDelay     = 1;
  int arbDropAfter = 1;
  int arbSeen      = 0;
  int arbHigh      = 0;
  bit arbDropped   = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // One clock of the arbiter: sample req at the negedge (the value the DUT
  // shows to the coming edge), decide gnt, and present it just after the edge,
  // which makes it a registered arbiter with a programmable grant delay.
  task automatic arbCycle();
    logic r;
    logic g;
    @(negedge clk);
    r = bus.req;
    if (r !== 1'b1) begin
      arbSeen    = 0;
      arbHigh    = 0;
      arbDropped = 1'b0;
    end else begin
      arbSeen++;
    end
    g = 1'b0;
    case (arbMode)
      NORMAL: g = (r === 1'b1) && (arbSeen >= arbDelay);
      STUCK:  g = (bus.gnt === 1'b1) || ((r === 1'b1) && (arbSeen >= arbDelay));
      DROP: begin
        if ((r === 1'b1) && (arbSeen >= arbDelay) && !arbDropped) begin
          if (arbHigh >= arbDropAfter) arbDropped = 1'b1;
          else begin
            g = 1'b1;
            arbHigh++;
          end
        end
      end
      default: g = 1'b0;
    endcase
    @(posedge clk);
    #1;
    bus.gnt = g;
  endtask

  // Idle cycles with gnt noise; nothing may move while no transaction runs.
  task automatic idleGap(input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.gnt = (i < n - 1) ? 1'($urandom) : 1'b0;
      checkOutput("idleReq",      32'(bus.req),  0);
      checkOutput("idleBusy",     32'(busy),     0);
      checkOutput("idleDone",     32'(done),     0);
      checkOutput("idleTimeout",  32'(timeout),  0);
      checkOutput("idleGntLost",  32'(gntLost),  0);
      checkOutput("idleLat",      32'(lat),      expLat);
      checkOutput("idleGrantCnt", 32'(grantCnt), expGrantCnt);
    end
  endtask

  // Run one transaction. Edge E0 is the edge that accepts start; every event
  // edge is derived from the arbiter parameters:
  //  grant sampled at E(d+1) when d <= TIMEOUT-1, giving lat = d;
  //  hold ends at E(d+2+h) unless gnt is first seen low earlier (gnt_lost);
  //  the release wait ends when gnt is first seen low, or TIMEOUT edges on.
  task automatic applyStimulus(input int mode, input int dly, input int dropAfter,
                               input int holdVal, input bit b2b);
    int  firstLow;
    int  relEdge;
    int  endEdge;
    int  lostEdge;
    int  gEdge;
    int  prevCnt;
    bit  granted;
    bit  normalEnd;

    arbMode      = mode;
    arbDelay     = dly;
    arbDropAfter = dropAfter;
    arbSeen      = 0;
    arbHigh      = 0;
    arbDropped   = 1'b0;

    granted  = (mode != NEVER) && (dly <= TIMEOUT - 1);
    lostEdge = -1;
    gEdge    = -1;
    if (!granted) begin
      relEdge   = TIMEOUT;
      endEdge   = TIMEOUT;
      normalEnd = 1'b0;
    end else begin
      gEdge    = dly + 1;
      firstLow = (mode == DROP) ? dly + dropAfter + 1 : 32'h3fff_ffff;
      relEdge  = dly + 2 + holdVal;
      if (firstLow <= relEdge) begin
        lostEdge = firstLow;
        relEdge  = firstLow;
      end
      if (mode == STUCK) begin
        endEdge   = relEdge + TIMEOUT;
        normalEnd = 1'b0;
      end else if (lostEdge >= 0) begin
        endEdge   = relEdge + 1;
        normalEnd = 1'b1;
      end else begin
        endEdge   = (firstLow < relEdge + 2) ? firstLow : relEdge + 2;
        normalEnd = 1'b1;
      end
    end
    prevCnt = expGrantCnt;

    start      = 1'b1;
    holdCycles = CNT_W'(holdVal);
    bus.gnt    = 1'b0;
    for (int k = 0; k <= endEdge; k++) begin
      arbCycle();
      if (b2b) start = 1'b1;
      else     start = (k < endEdge) ? 1'($urandom) : 1'b0;
      holdCycles = CNT_W'($urandom);
      if (granted && k >= gEdge) expLat = dly;
      if (normalEnd && k == endEdge)
        expGrantCnt = (prevCnt == 65535) ? prevCnt : prevCnt + 1;
      checkOutput("req",      32'(bus.req),  32'(k < relEdge));
      checkOutput("busy",     32'(busy),     32'(k < endEdge));
      checkOutput("done",     32'(done),     32'(normalEnd && k == endEdge));
      checkOutput("timeout",  32'(timeout),  32'(!normalEnd && k == endEdge));
      checkOutput("gntLost",  32'(gntLost),  32'(k == lostEdge));
      checkOutput("lat",      32'(lat),      expLat);
      checkOutput("grantCnt", 32'(grantCnt), expGrantCnt);
    end
    bus.gnt = 1'b0;
  endtask

  initial begin
    int mode;
    int dly;
    int h;

    rst_n      = 1'b0;
    start      = 1'b0;
    holdCycles = '0;
    bus.gnt    = 1'b0;

    // Reset state.
    #12;
    checkOutput("rstReq",      32'(bus.req),  0);
    checkOutput("rstBusy",     32'(busy),     0);
    checkOutput("rstDone",     32'(done),     0);
    checkOutput("rstTimeout",  32'(timeout),  0);
    checkOutput("rstGntLost",  32'(gntLost),  0);
    checkOutput("rstLat",      32'(lat),      0);
    checkOutput("rstGrantCnt", 32'(grantCnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases from the handshake rules.
    $display("[TB] directed transactions");
    applyStimulus(NORMAL, 1, 0, 3, 1'b0);            idleGap(2);
    applyStimulus(NEVER, 1, 0, 4, 1'b0);             idleGap(2);
    applyStimulus(DROP, 1, 2, 5, 1'b0);              idleGap(2);
    applyStimulus(STUCK, 1, 0, 2, 1'b0);             idleGap(2);
    applyStimulus(NORMAL, TIMEOUT - 1, 0, 0, 1'b0);  idleGap(2);
    applyStimulus(NORMAL, TIMEOUT, 0, 0, 1'b0);      idleGap(2);
    applyStimulus(DROP, 3, 1, 0, 1'b0);              idleGap(2);

    // Start held high: each transaction is accepted on the first idle edge.
    $display("[TB] back-to-back transactions");
    for (int i = 0; i < 10; i++) applyStimulus(NORMAL, 1, 0, 0, 1'b1);
    idleGap(2);

    // Randomized transactions.
    $display("[TB] random transactions");
    for (int i = 0; i < 150; i++) begin
      mode = int'($urandom_range(0, 3));
      dly  = int'($urandom_range(1, TIMEOUT + 2));
      h    = int'($urandom_range(0, 10));
      applyStimulus(mode, dly, int'($urandom_range(1, h + 3)), h, 1'($urandom));
      idleGap(int'($urandom_range(1, 3)));
    end

    // Asynchronous reset in the middle of HOLD.
    $display("[TB] reset during hold");
    arbMode    = NORMAL;
    arbDelay   = 1;
    arbSeen    = 0;
    arbHigh    = 0;
    arbDropped = 1'b0;
    start      = 1'b1;
    holdCycles = CNT_W'(5);
    bus.gnt    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      arbCycle();
      start = 1'b0;
    end
    checkOutput("preRstReq",  32'(bus.req), 1);
    checkOutput("preRstBusy", 32'(busy),    1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstReq",      32'(bus.req),  0);
    checkOutput("midRstBusy",     32'(busy),     0);
    checkOutput("midRstDone",     32'(done),     0);
    checkOutput("midRstTimeout",  32'(timeout),  0);
    checkOutput("midRstGntLost",  32'(gntLost),  0);
    checkOutput("midRstLat",      32'(lat),      0);
    checkOutput("midRstGrantCnt", 32'(grantCnt), 0);
    expLat      = 0;
    expGrantCnt = 0;
    bus.gnt     = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(NORMAL, 1, 0, 2, 1'b0);
    checkOutput("postRstLat", 32'(lat), 1);
    idleGap(2);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/req_initiator.md
Name: req_initiator

Overview:
- Requester side of the single-bit req/gnt handshake. The arbiter side returns gnt registered, one clock after it samples req.
- On a start pulse the block raises req and waits for gnt. It then holds req for a programmed number of cycles, releases req and waits for gnt to drop.
- It reports grant latency, timeouts and protocol errors.
- It drives the req signal of the req/gnt interface in the testbench, replacing hand-written stimulus.

Parameters:
- TIMEOUT, 16, max cycles req waits for gnt (REQ) or for gnt release (RELEASE). Legal range 1..2**CNT_W-1.
- CNT_W, 8, width of the latency and hold counters.

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse requesting a transaction; ignored unless busy==0
- hold_cycles  input  CNT_W  cycles to keep req high after grant; latched on accepted start
- gnt  input  1  grant from the arbiter
- req  output  1  request to the arbiter, registered
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when a transaction completes normally
- timeout  output  1  one-cycle pulse when a wait exceeds TIMEOUT
- gnt_lost  output  1  one-cycle pulse when gnt drops while in HOLD
- lat  output  CNT_W  grant latency of the last granted transaction
- grant_cnt  output  16  saturating count of completed transactions

Behaviour:
- Reset: asynchronous on rst_n low. state=IDLE; req, busy, done, timeout and gnt_lost = 0; lat=0; grant_cnt=0; internal counters=0. Reset mid-transaction drops req immediately.
- All outputs are registered. Pulse outputs are high for exactly one cycle.
- IDLE:
  - On an edge with start=1: go to REQ, set req<=1 and busy<=1, latch hold_cycles, clear the latency/timeout counter.
- REQ:
  - Edge with gnt=1: lat<=counter, go to HOLD, load hold counter with the latched hold_cycles.
  - Edge with gnt=0 and counter==TIMEOUT-1: req<=0, timeout<=1, go to IDLE, busy<=0. Result: req is high for exactly TIMEOUT cycles.
  - Otherwise: counter+1.
- HOLD:
  - Edge with gnt=0: gnt_lost<=1, req<=0, go to RELEASE with the counter cleared.
  - Else if hold counter==0: req<=0, go to RELEASE with the counter cleared.
  - Else: hold counter-1.
  - hold_cycles=0 therefore gives exactly one HOLD cycle.
- RELEASE:
  - Edge with gnt=0: done<=1, grant_cnt+1 (saturates at 16'hFFFF), busy<=0, go to IDLE.
  - Edge with gnt=1 and counter==TIMEOUT-1: timeout<=1, busy<=0, go to IDLE; grant_cnt unchanged.
  - Otherwise: counter+1.
- Latency reference: with the registered arbiter, gnt is first sampled high on the 2nd edge after req rises, so lat=1. A combinational arbiter gives lat=0.
- Ignored inputs:
  - start while busy=1, including the cycle done is high, is dropped and not queued.
  - gnt high in IDLE is ignored.
- hold_cycles changing after acceptance has no effect on the current transaction.
- Simultaneous gnt=1 and timeout limit in REQ: grant wins, no timeout.

Decomposition:
- Package req_pkg holds:
  - typedef enum logic [1:0] state_t {IDLE, REQ, HOLD, RELEASE};
  - localparam GRANT_CNT_W=16.
- No sub-module. One counter is shared between the latency/timeout wait in REQ and the wait in RELEASE. The hold counter is separate.

Test Plan:
- Registered arbiter, start with hold_cycles=3 on edge E0: req high E0..E6 (6 cycles), lat=1, done pulse on the edge after gnt falls (E8), grant_cnt=1, busy low afterwards.
- Arbiter tied gnt=0, TIMEOUT=16, start: req high exactly 16 cycles, timeout pulse once, done never, grant_cnt=0, lat unchanged.
- Arbiter forcing gnt low after 1 cycle in HOLD with hold_cycles=5: gnt_lost pulse, req falls next edge, done follows once gnt sampled low, grant_cnt increments.
- gnt stuck at 1 after grant: RELEASE times out after 16 cycles, timeout pulse, grant_cnt unchanged, busy=0.
- start pulsed every cycle for 10 back-to-back transactions with hold_cycles=0: only starts while busy=0 are accepted, grant_cnt equals the number of done pulses, req never high while busy=0.
- rst_n asserted mid-HOLD, asynchronous to clk: req, busy and all pulses drop before the next edge, lat=0, grant_cnt=0; a new start after release completes normally with lat=1.
